// File: rtl/ucsbece154_icache_pkg.sv
// rtl/ucsbece154_icache_pkg.sv - shared defaults, FSM encoding and address helpers for the instruction cache
package ucsbece154_icache_pkg;

    localparam int ICACHE_NUM_SETS    = 8;
    localparam int ICACHE_BLOCK_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_REQ           = 3'd1,
        ST_WAIT          = 3'd2,
        ST_FILL_DEMAND   = 3'd3,
        ST_FILL_PREFETCH = 3'd4
    } icache_state_t;

    function automatic int offset_bits(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

endpackage

// File: rtl/ucsbece154_icache_array.sv
// rtl/ucsbece154_icache_array.sv - valid/tag/data storage with one async read index and one write port
module ucsbece154_icache_array
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = ICACHE_NUM_SETS,
    parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS,
    parameter int INDEX_W     = $clog2(NUM_SETS),
    parameter int TAG_W       = 32 - offset_bits(BLOCK_WORDS) - $clog2(NUM_SETS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INDEX_W-1:0]           rd_index,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [BLOCK_WORDS-1:0][31:0] rd_data,
    input  logic [INDEX_W-1:0]           wr_index,
    input  logic [BLOCK_WORDS-1:0]       wr_word_en,
    input  logic [BLOCK_WORDS-1:0][31:0] wr_data,
    input  logic                         wr_tag_en,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic                         wr_valid_set,
    input  logic                         wr_valid_clr
);

    logic [NUM_SETS-1:0]          valid_q, valid_d;
    logic [TAG_W-1:0]             tag_q  [NUM_SETS];
    logic [TAG_W-1:0]             tag_d  [NUM_SETS];
    logic [BLOCK_WORDS-1:0][31:0] data_q [NUM_SETS];
    logic [BLOCK_WORDS-1:0][31:0] data_d [NUM_SETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // set wins over clear so a single-beat fill ends valid
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_valid_clr) valid_d[wr_index] = 1'b0;
        if (wr_valid_set) valid_d[wr_index] = 1'b1;
        if (wr_tag_en)    tag_d[wr_index]   = wr_tag;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            if (wr_word_en[w]) data_d[wr_index][w] = wr_data[w];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/ucsbece154_icache.sv
// rtl/ucsbece154_icache.sv - direct-mapped icache with critical-word-first fill and one-block prefetch buffer
module ucsbece154_icache
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = ICACHE_NUM_SETS,
    parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int OB     = offset_bits(BLOCK_WORDS);
    localparam int WOFF_W = $clog2(BLOCK_WORDS);
    localparam int IW     = $clog2(NUM_SETS);
    localparam int TW     = 32 - OB - IW;
    localparam int BA_W   = 32 - OB;
    localparam int CW     = $clog2(2 * BLOCK_WORDS) + 1;
    localparam logic [CW-1:0] DEMAND_LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] PF_LAST     = CW'(2 * BLOCK_WORDS - 1);

    icache_state_t                state_q, state_d;
    logic [CW-1:0]                beat_q, beat_d;
    logic [31:0]                  miss_addr_q, miss_addr_d;
    logic                         pf_valid_q, pf_valid_d;
    logic [BA_W-1:0]              pf_block_q, pf_block_d;
    logic [BLOCK_WORDS-1:0][31:0] pf_data_q, pf_data_d;

    logic [WOFF_W-1:0] rd_off, miss_off, fill_word;
    logic [IW-1:0]     rd_idx, miss_idx;
    logic [TW-1:0]     rd_tag_addr, miss_tag;
    logic [BA_W-1:0]   rd_block, miss_block;
    logic              addr_unused;

    assign rd_off      = ReadAddress[OB-1:2];
    assign rd_idx      = ReadAddress[OB+IW-1:OB];
    assign rd_tag_addr = ReadAddress[31:OB+IW];
    assign rd_block    = ReadAddress[31:OB];
    assign addr_unused = ^ReadAddress[1:0];
    assign miss_off    = miss_addr_q[OB-1:2];
    assign miss_idx    = miss_addr_q[OB+IW-1:OB];
    assign miss_tag    = miss_addr_q[31:OB+IW];
    assign miss_block  = miss_addr_q[31:OB];
    assign fill_word   = miss_off + beat_q[WOFF_W-1:0];

    logic                         line_valid;
    logic [TW-1:0]                line_tag;
    logic [BLOCK_WORDS-1:0][31:0] line_data;
    logic [IW-1:0]                wr_index;
    logic [BLOCK_WORDS-1:0]       wr_word_en;
    logic [BLOCK_WORDS-1:0][31:0] wr_data;
    logic                         wr_tag_en, wr_valid_set, wr_valid_clr;
    logic [TW-1:0]                wr_tag;
    logic                         cache_hit, pf_hit;

    ucsbece154_icache_array #(
        .NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS), .INDEX_W(IW), .TAG_W(TW)
    ) u_array (
        .clk(clk), .reset(reset),
        .rd_index(rd_idx), .rd_valid(line_valid), .rd_tag(line_tag), .rd_data(line_data),
        .wr_index(wr_index), .wr_word_en(wr_word_en), .wr_data(wr_data),
        .wr_tag_en(wr_tag_en), .wr_tag(wr_tag),
        .wr_valid_set(wr_valid_set), .wr_valid_clr(wr_valid_clr)
    );

    assign cache_hit      = line_valid && (line_tag == rd_tag_addr);
    assign pf_hit         = pf_valid_q && (pf_block_q == rd_block);
    assign MemReadAddress = miss_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            pf_valid_q  <= 1'b0;
            pf_block_q  <= '0;
            pf_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            pf_valid_q  <= pf_valid_d;
            pf_block_q  <= pf_block_d;
            pf_data_q   <= pf_data_d;
        end
    end

    // beat counter advances on MemDataReady only, so imem may insert idle cycles
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_addr_d = miss_addr_q;
        pf_valid_d  = pf_valid_q;
        pf_block_d  = pf_block_q;
        pf_data_d   = pf_data_q;
        case (state_q)
            ST_IDLE: begin
                if (ReadEnable && pf_hit) begin
                    pf_valid_d = 1'b0;
                end else if (ReadEnable && !cache_hit) begin
                    miss_addr_d = {ReadAddress[31:2], 2'b00};
                    pf_valid_d  = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                beat_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT, ST_FILL_DEMAND: begin
                if (MemDataReady) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = (beat_q == DEMAND_LAST) ? ST_FILL_PREFETCH : ST_FILL_DEMAND;
                end
            end
            ST_FILL_PREFETCH: begin
                if (MemDataReady) begin
                    pf_data_d[beat_q[WOFF_W-1:0]] = MemDataIn;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == PF_LAST) begin
                        pf_valid_d = 1'b1;
                        pf_block_d = miss_block + 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Ready          = 1'b0;
        Instruction    = '0;
        MemReadRequest = 1'b0;
        wr_index       = rd_idx;
        wr_word_en     = '0;
        wr_data        = pf_data_q;
        wr_tag         = rd_tag_addr;
        wr_tag_en      = 1'b0;
        wr_valid_set   = 1'b0;
        wr_valid_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ReadEnable && (cache_hit || pf_hit)) begin
                    Ready       = 1'b1;
                    Instruction = cache_hit ? line_data[rd_off] : pf_data_q[rd_off];
                    if (pf_hit) begin
                        wr_word_en   = '1;
                        wr_tag_en    = 1'b1;
                        wr_valid_set = 1'b1;
                    end
                end
            end
            ST_REQ: MemReadRequest = 1'b1;
            ST_WAIT, ST_FILL_DEMAND: begin
                if (MemDataReady) begin
                    wr_index              = miss_idx;
                    wr_tag                = miss_tag;
                    wr_word_en[fill_word] = 1'b1;
                    wr_data[fill_word]    = MemDataIn;
                    if (beat_q == '0) begin
                        Ready        = ReadEnable;
                        Instruction  = ReadEnable ? MemDataIn : '0;
                        wr_valid_clr = 1'b1;
                    end
                    if (beat_q == DEMAND_LAST) begin
                        wr_tag_en    = 1'b1;
                        wr_valid_set = 1'b1;
                    end
                end
            end
            ST_FILL_PREFETCH: begin
                if (ReadEnable && cache_hit) begin
                    Ready       = 1'b1;
                    Instruction = line_data[rd_off];
                end
            end
            default: ;
        endcase
    end

endmodule
